// File: rtl/histogram_equalization_mc_pkg.sv
// rtl/histogram_equalization_mc_pkg.sv - shared types, error bit indices and sizing helpers
// for the multi-channel histogram equalizer
package hist_eq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    CDF,
    SWAP
  } hist_eq_state_e;

  localparam int ERR_OVR = 0;
  localparam int ERR_SAT = 1;
  localparam int ERR_CNT = 2;

  function automatic int hist_eq_wd_bin(input int n);
    return $clog2(n + 1);
  endfunction

  // Rounded normalization constant: (2^w-1)/n with shf fraction bits
  function automatic logic [63:0] hist_eq_k(input int w, input int shf, input int n);
    logic [63:0] num;
    num = ((64'd1 << w) - 64'd1) << shf;
    return (num + 64'(n / 2)) / 64'(n);
  endfunction

endpackage

// File: rtl/histogram_equalization_mc_if.sv
// rtl/histogram_equalization_mc_if.sv - pixel in/out and status bundle of the equalizer;
// HIST_EQ_STATS_EN adds the per-channel min/max statistics signals
interface histogram_equalization_mc_if #(
  parameter int NB_CHN      = 3,
  parameter int WD_IMG_DATA = 8,
  parameter int WD_ERR_INFO = 4
);
  localparam int WD_PIX = NB_CHN * WD_IMG_DATA;

  logic                   s_img_c_fsync;
  logic                   s_img_c_vsync;
  logic                   s_img_c_hsync;
  logic [WD_PIX-1:0]      s_img_y_mdat0;
  logic                   m_img_c_fsync;
  logic                   m_img_c_vsync;
  logic                   m_img_c_hsync;
  logic [WD_PIX-1:0]      m_img_y_mdat0;
  logic                   m_lut_valid;
  logic [WD_ERR_INFO-1:0] m_err_info;
`ifdef HIST_EQ_STATS_EN
  logic [WD_PIX-1:0]      m_stat_min;
  logic [WD_PIX-1:0]      m_stat_max;
`endif

  modport master (
    output s_img_c_fsync, s_img_c_vsync, s_img_c_hsync, s_img_y_mdat0,
    input  m_img_c_fsync, m_img_c_vsync, m_img_c_hsync, m_img_y_mdat0,
    input  m_lut_valid, m_err_info
`ifdef HIST_EQ_STATS_EN
    , input m_stat_min, m_stat_max
`endif
  );

  modport slave (
    input  s_img_c_fsync, s_img_c_vsync, s_img_c_hsync, s_img_y_mdat0,
    output m_img_c_fsync, m_img_c_vsync, m_img_c_hsync, m_img_y_mdat0,
    output m_lut_valid, m_err_info
`ifdef HIST_EQ_STATS_EN
    , output m_stat_min, m_stat_max
`endif
  );

endinterface

// File: rtl/histogram_equalization_mc_chan.sv
// rtl/histogram_equalization_mc_chan.sv - one channel: histogram RAM with RMW forwarding,
// CDF/normalize datapath and double-buffered LUT; HIST_EQ_STATS_EN adds min/max tracking
module hist_eq_chan #(
  parameter int WD_IMG_DATA = 8,
  parameter int WD_BIN      = 9,
  parameter int NB_SCL_SHF  = 24,
  parameter logic [WD_IMG_DATA+NB_SCL_SHF-1:0] K = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_en,
  input  logic [WD_IMG_DATA-1:0] pix,
  input  logic                   clr_en,
  input  logic                   cdf_en,
  input  logic [WD_IMG_DATA-1:0] idx,
  input  logic                   bank_sel,
  input  logic                   lut_valid,
  output logic                   sat,
  output logic [WD_IMG_DATA-1:0] dat_out
`ifdef HIST_EQ_STATS_EN
  , input  logic                   frame_start
  , input  logic                   swap
  , output logic [WD_IMG_DATA-1:0] stat_min
  , output logic [WD_IMG_DATA-1:0] stat_max
`endif
);
  localparam int W      = WD_IMG_DATA;
  localparam int NB_BIN = 1 << W;
  localparam int SUM_W  = WD_BIN + W;
  localparam int PRD_W  = SUM_W + W + NB_SCL_SHF;

  logic [WD_BIN-1:0] hist [NB_BIN];
  logic [W-1:0]      lut0 [NB_BIN];
  logic [W-1:0]      lut1 [NB_BIN];

  logic [W-1:0]      rd_addr, wr_addr, a_q, p1;
  logic [WD_BIN-1:0] rd_val, rd_q, inc_val, wr_val;
  logic              v_q, wr_en;
  logic [SUM_W-1:0]  sum, sum_nxt;
  logic [PRD_W-1:0]  prod, scaled;
  logic [W-1:0]      lut_val;

  // The write of the previous sample lands this cycle, so a same-bin read takes it directly
  always_comb begin
    rd_addr = cdf_en ? idx : pix;
    rd_val  = hist[rd_addr];
    if (v_q && (a_q == rd_addr)) rd_val = inc_val;
  end

  always_comb begin
    sat     = v_q & (&rd_q);
    inc_val = (&rd_q) ? rd_q : rd_q + WD_BIN'(1);
    wr_en   = clr_en | cdf_en | v_q;
    wr_addr = (clr_en | cdf_en) ? idx : a_q;
    wr_val  = (clr_en | cdf_en) ? '0 : inc_val;
  end

  always_ff @(posedge clk) begin
    if (wr_en) hist[wr_addr] <= wr_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= 1'b0;
      a_q  <= '0;
      rd_q <= '0;
    end else begin
      v_q  <= acc_en;
      a_q  <= pix;
      rd_q <= rd_val;
    end
  end

  always_comb begin
    sum_nxt = sum + SUM_W'(rd_val);
    prod    = PRD_W'(sum_nxt) * PRD_W'(K);
    scaled  = prod >> NB_SCL_SHF;
    lut_val = (scaled > PRD_W'(NB_BIN - 1)) ? '1 : scaled[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else     sum <= cdf_en ? sum_nxt : '0;
  end

  // bank_sel names the active bank; the CDF always fills the other one
  always_ff @(posedge clk) begin
    if (cdf_en) begin
      if (bank_sel) lut0[idx] <= lut_val;
      else          lut1[idx] <= lut_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1      <= '0;
      dat_out <= '0;
    end else begin
      p1      <= pix;
      dat_out <= lut_valid ? (bank_sel ? lut1[p1] : lut0[p1]) : p1;
    end
  end

`ifdef HIST_EQ_STATS_EN
  logic [W-1:0] run_min, run_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min  <= '1;
      run_max  <= '0;
      stat_min <= '0;
      stat_max <= '0;
    end else begin
      if (frame_start) begin
        run_min <= '1;
        run_max <= '0;
      end else if (acc_en) begin
        if (pix < run_min) run_min <= pix;
        if (pix > run_max) run_max <= pix;
      end
      if (swap) begin
        stat_min <= run_min;
        stat_max <= run_max;
      end
    end
  end
`endif

endmodule

// File: rtl/histogram_equalization_mc.sv
// rtl/histogram_equalization_mc.sv - top: frame FSM, pixel counter, error flags, sync delay
// line and per-channel instances; HIST_EQ_STATS_EN enables the min/max statistics outputs
module histogram_equalization_mc
  import hist_eq_pkg::*;
#(
  parameter int NB_CHN      = 3,
  parameter int NB_IMG_HORI = 480,
  parameter int NB_IMG_VERT = 320,
  parameter int WD_IMG_DATA = 8,
  parameter int NB_SCL_SHF  = 24,
  parameter int WD_ERR_INFO = 4
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  histogram_equalization_mc_if.slave img
);
  localparam int W      = WD_IMG_DATA;
  localparam int N      = NB_IMG_HORI * NB_IMG_VERT;
  localparam int WD_BIN = hist_eq_wd_bin(N);
  localparam int CNT_W  = WD_BIN + 1;
  localparam int K_W    = W + NB_SCL_SHF;
  localparam logic [K_W-1:0] K = K_W'(hist_eq_k(W, NB_SCL_SHF, N));

  hist_eq_state_e state, nxt;

  logic              fsync_q, rise;
  logic              acc_en, clr_en, cdf_en, swap, frame_start, ovr;
  logic [W-1:0]      idx;
  logic [CNT_W-1:0]  cnt;
  logic              lut_valid, bank_sel;
  logic [2:0]        err;
  logic [NB_CHN-1:0] sat;
  logic              f1, v1, h1, f2, v2, h2;
  logic [NB_CHN*W-1:0] pix_out;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state <= CLEAR;
    else           state <= nxt;
  end

  always_comb begin
    nxt         = state;
    rise        = img.s_img_c_fsync & ~fsync_q;
    acc_en      = 1'b0;
    clr_en      = 1'b0;
    cdf_en      = 1'b0;
    swap        = 1'b0;
    frame_start = 1'b0;
    ovr         = 1'b0;
    case (state)
      CLEAR: begin
        clr_en = 1'b1;
        ovr    = rise;
        if (&idx) nxt = IDLE;
      end
      IDLE: begin
        if (rise) begin
          frame_start = 1'b1;
          nxt         = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = img.s_img_c_fsync & img.s_img_c_hsync;
        if (!img.s_img_c_fsync) nxt = CDF;
      end
      CDF: begin
        cdf_en = 1'b1;
        ovr    = rise;
        if (&idx) nxt = SWAP;
      end
      SWAP: begin
        swap = 1'b1;
        ovr  = rise;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      fsync_q   <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      lut_valid <= 1'b0;
      bank_sel  <= 1'b0;
      err       <= '0;
    end else begin
      fsync_q <= img.s_img_c_fsync;
      idx     <= (clr_en | cdf_en) ? idx + W'(1) : '0;
      if (frame_start)           cnt <= '0;
      else if (acc_en && ~&cnt)  cnt <= cnt + CNT_W'(1);
      if (swap) begin
        lut_valid <= 1'b1;
        bank_sel  <= ~bank_sel;
      end
      if (ovr)  err[ERR_OVR] <= 1'b1;
      if (|sat) err[ERR_SAT] <= 1'b1;
      if (state == ACCUM && !img.s_img_c_fsync && cnt != CNT_W'(N)) err[ERR_CNT] <= 1'b1;
    end
  end

  // Syncs follow the two-stage data path (input register, LUT read)
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      {f1, v1, h1} <= '0;
      {f2, v2, h2} <= '0;
    end else begin
      {f1, v1, h1} <= {img.s_img_c_fsync, img.s_img_c_vsync, img.s_img_c_hsync};
      {f2, v2, h2} <= {f1, v1, h1};
    end
  end

  assign img.m_img_c_fsync = f2;
  assign img.m_img_c_vsync = v2;
  assign img.m_img_c_hsync = h2;
  assign img.m_img_y_mdat0 = pix_out;
  assign img.m_lut_valid   = lut_valid;

  always_comb begin
    img.m_err_info      = '0;
    img.m_err_info[2:0] = err;
  end

`ifdef HIST_EQ_STATS_EN
  logic [NB_CHN*W-1:0] stat_min, stat_max;
  assign img.m_stat_min = stat_min;
  assign img.m_stat_max = stat_max;
`endif

  for (genvar ch = 0; ch < NB_CHN; ch++) begin : g_chan
    hist_eq_chan #(
      .WD_IMG_DATA (W),
      .WD_BIN      (WD_BIN),
      .NB_SCL_SHF  (NB_SCL_SHF),
      .K           (K)
    ) u_chan (
      .clk         (i_sys_clk),
      .rst         (i_sys_rst),
      .acc_en      (acc_en),
      .pix         (img.s_img_y_mdat0[ch*W +: W]),
      .clr_en      (clr_en),
      .cdf_en      (cdf_en),
      .idx         (idx),
      .bank_sel    (bank_sel),
      .lut_valid   (lut_valid),
      .sat         (sat[ch]),
      .dat_out     (pix_out[ch*W +: W])
`ifdef HIST_EQ_STATS_EN
      , .frame_start (frame_start)
      , .swap        (swap)
      , .stat_min    (stat_min[ch*W +: W])
      , .stat_max    (stat_max[ch*W +: W])
`endif
    );
  end

endmodule

// File: tb/tb_histogram_equalization_mc.sv
// tb/tb_histogram_equalization_mc.sv - directed bench, one channel, 16x16 frames, W=8;
// HIST_EQ_STATS_EN additionally checks the min/max statistics
module tb_histogram_equalization_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  histogram_equalization_mc_if #(.NB_CHN(1), .WD_IMG_DATA(8), .WD_ERR_INFO(4)) bus ();

  histogram_equalization_mc #(
    .NB_CHN      (1),
    .NB_IMG_HORI (16),
    .NB_IMG_VERT (16),
    .WD_IMG_DATA (8),
    .NB_SCL_SHF  (24),
    .WD_ERR_INFO (4)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .img       (bus)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // One-cycle pixel outside any frame; the remapped value appears two cycles later
  task automatic probe(input string tag, input logic [7:0] x, input logic [7:0] exp);
    bus.s_img_y_mdat0 = x;
    bus.s_img_c_hsync = 1'b1;
    tick();
    bus.s_img_c_hsync = 1'b0;
    tick();
    check_vec(tag, 32'(bus.m_img_y_mdat0), 32'(exp));
  endtask

  task automatic send_frame(input logic [7:0] val, input int n, input bit ramp);
    bus.s_img_c_fsync = 1'b1;
    tick();
    tick();
    check_vec("fsync_dly", 32'(bus.m_img_c_fsync), 32'd1);
    for (int i = 0; i < n; i++) begin
      bus.s_img_c_hsync = 1'b1;
      bus.s_img_y_mdat0 = ramp ? 8'(i) : val;
      tick();
    end
    bus.s_img_c_hsync = 1'b0;
    bus.s_img_c_fsync = 1'b0;
    tick();
  endtask

  initial begin
    bus.s_img_c_fsync = 1'b0;
    bus.s_img_c_vsync = 1'b0;
    bus.s_img_c_hsync = 1'b0;
    bus.s_img_y_mdat0 = '0;
    gap(3);
    check_vec("rst_dat",   32'(bus.m_img_y_mdat0), 32'd0);
    check_vec("rst_valid", 32'(bus.m_lut_valid),   32'd0);
    check_vec("rst_err",   32'(bus.m_err_info),    32'd0);
    rst = 1'b0;

    // Two-cycle latency of syncs and pass-through data
    bus.s_img_c_vsync = 1'b1;
    bus.s_img_c_hsync = 1'b1;
    bus.s_img_y_mdat0 = 8'h5a;
    tick();
    check_vec("lat1_hsync", 32'(bus.m_img_c_hsync), 32'd0);
    bus.s_img_c_vsync = 1'b0;
    bus.s_img_c_hsync = 1'b0;
    tick();
    check_vec("lat2_hsync", 32'(bus.m_img_c_hsync), 32'd1);
    check_vec("lat2_vsync", 32'(bus.m_img_c_vsync), 32'd1);
    check_vec("pass_dat",   32'(bus.m_img_y_mdat0), 32'h5a);
    gap(300);

    // Ramp frame: lut[i] = floor((i+1)*255/256)
    send_frame(8'd0, 256, 1'b1);
    gap(300);
    check_vec("ramp_valid", 32'(bus.m_lut_valid), 32'd1);
    check_vec("ramp_err",   32'(bus.m_err_info),  32'd0);
    probe("ramp_0",   8'd0,   8'd0);
    probe("ramp_64",  8'd64,  8'd64);
    probe("ramp_127", 8'd127, 8'd127);
    probe("ramp_255", 8'd255, 8'd255);

    send_frame(8'd100, 256, 1'b0);
    gap(300);
    probe("c100_99",  8'd99,  8'd0);
    probe("c100_100", 8'd100, 8'd255);
    probe("c100_200", 8'd200, 8'd255);
`ifdef HIST_EQ_STATS_EN
    check_vec("stat_min", 32'(bus.m_stat_min), 32'd100);
    check_vec("stat_max", 32'(bus.m_stat_max), 32'd100);
`endif

    // Back-to-back hits on one bin: every increment must survive forwarding
    send_frame(8'd7, 256, 1'b0);
    gap(300);
    probe("fwd_6", 8'd6, 8'd0);
    probe("fwd_7", 8'd7, 8'd255);
    probe("fwd_0", 8'd0, 8'd0);
    check_vec("fwd_err", 32'(bus.m_err_info), 32'd0);

    // Short frame: count error, LUT still swaps (200*255/256 -> 199)
    send_frame(8'd50, 200, 1'b0);
    gap(300);
    check_vec("short_err",   32'(bus.m_err_info),  32'b0100);
    check_vec("short_valid", 32'(bus.m_lut_valid), 32'd1);
    probe("short_49",  8'd49,  8'd0);
    probe("short_50",  8'd50,  8'd199);
    probe("short_255", 8'd255, 8'd199);

    // Overrun: next frame starts 10 cycles after the fall, during CDF
    send_frame(8'd30, 256, 1'b0);
    gap(9);
    bus.s_img_c_fsync = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.s_img_c_hsync = 1'b1;
      bus.s_img_y_mdat0 = 8'd60;
      tick();
    end
    check_vec("ovr_old_lut", 32'(bus.m_img_y_mdat0), 32'd199);
    bus.s_img_c_hsync = 1'b0;
    bus.s_img_c_fsync = 1'b0;
    tick();
    gap(300);
    check_vec("ovr_err", 32'(bus.m_err_info), 32'b0101);
    probe("ovr_29", 8'd29, 8'd0);
    probe("ovr_30", 8'd30, 8'd255);

    send_frame(8'd80, 256, 1'b0);
    gap(300);
    probe("post_ovr_70", 8'd70, 8'd0);
    probe("post_ovr_79", 8'd79, 8'd0);
    probe("post_ovr_80", 8'd80, 8'd255);

    // Reset in the middle of the CDF walk (bin 50)
    send_frame(8'd90, 256, 1'b0);
    gap(48);
    bus.s_img_y_mdat0 = 8'd100;
    bus.s_img_c_hsync = 1'b1;
    tick();
    tick();
    check_vec("pre_rst_dat", 32'(bus.m_img_y_mdat0), 32'd255);
    rst = 1'b1;
    #1;
    check_vec("mid_rst_dat",   32'(bus.m_img_y_mdat0), 32'd0);
    check_vec("mid_rst_hsync", 32'(bus.m_img_c_hsync), 32'd0);
    check_vec("mid_rst_valid", 32'(bus.m_lut_valid),   32'd0);
    check_vec("mid_rst_err",   32'(bus.m_err_info),    32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_vec("post_rst_pass",  32'(bus.m_img_y_mdat0), 32'd100);
    check_vec("post_rst_valid", 32'(bus.m_lut_valid),   32'd0);
    bus.s_img_c_hsync = 1'b0;
    gap(300);

    // Stale bin 90 must have been wiped by the restarted clear walk
    send_frame(8'd100, 256, 1'b0);
    gap(300);
    check_vec("rec_valid", 32'(bus.m_lut_valid), 32'd1);
    check_vec("rec_err",   32'(bus.m_err_info),  32'd0);
    probe("rec_95",  8'd95,  8'd0);
    probe("rec_100", 8'd100, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/histogram_equalization_mc.md
# histogram_equalization_mc

Multi-channel, self-contained histogram equalizer for the gray/colour image pipeline. It accumulates one histogram per channel over a frame in internal RAM and, after the frame ends, walks the bins to build a normalized CDF look-up table per channel. Incoming pixels are remapped through the LUT of the previous frame. Unlike the single-channel design with an external BRAM, this block owns its storage, double-buffers the LUTs, supports back-to-back pixels and reports frame errors.

## Interface
- NB_CHN, 3, independent channels packed in one pixel word
- NB_IMG_HORI, 480, pixels per line
- NB_IMG_VERT, 320, lines per frame
- WD_IMG_DATA, 8, bits per channel sample; bins = 2^WD_IMG_DATA
- NB_SCL_SHF, 24, fraction bits of the normalization constant
- WD_ERR_INFO, 4, error vector width
- i_sys_clk  in  1  single clock; all logic on its rising edge
- i_sys_rst  in  1  asynchronous, active-high reset
- s_img_c_fsync  in  1  frame active
- s_img_c_vsync  in  1  line active
- s_img_c_hsync  in  1  pixel valid, one pixel per high cycle
- s_img_y_mdat0  in  NB_CHN*WD_IMG_DATA  pixel, channel 0 in LSBs
- m_img_c_fsync / m_img_c_vsync / m_img_c_hsync  out  1  inputs delayed 2 cycles
- m_img_y_mdat0  out  NB_CHN*WD_IMG_DATA  remapped pixel
- m_lut_valid  out  1  a completed LUT is active
- m_err_info  out  WD_ERR_INFO  sticky error flags

## Operation
- N = NB_IMG_HORI*NB_IMG_VERT. Bin width WD_BIN = $clog2(N+1). K = (((2^W-1) << NB_SCL_SHF) + N/2) / N, computed at elaboration.
- FSM states: IDLE, ACCUM, CDF, SWAP.
- **IDLE → ACCUM:** on the rising edge of fsync. The pixel counter clears.
- **ACCUM:**
  - Each hsync cycle does a read-modify-write of bin[pix], per channel.
  - If the same bin is hit on consecutive cycles, the in-flight value is forwarded. No increment may be lost.
  - A bin saturates at 2^WD_BIN-1 and sets err[1].
- **ACCUM → CDF:** on the falling edge of fsync.
  - If the pixel count ≠ N, set err[2].
  - The CDF still runs.
- **CDF:** runs i = 0 .. 2^W-1, one bin per cycle.
  - sum += bin[i].
  - shadow_lut[i] = min((sum*K) >> NB_SCL_SHF, 2^W-1).
  - bin[i] is cleared to 0 in the same cycle.
- **SWAP (1 cycle):** exchange the active and shadow banks, set m_lut_valid = 1, go to IDLE.
- **Remap:**
  - Output = active_lut[pix] per channel when m_lut_valid = 1.
  - Otherwise the pixel passes through unchanged.
  - Remap runs continuously, independent of the FSM state.
- **Overrun:** fsync rising while in CDF or SWAP sets err[0].
  - That frame is remapped with the current active LUT but is not accumulated.
  - The FSM stays in IDLE until the next fsync rising edge.
- err[3] is reserved and reads 0. Error flags clear only on reset.

## Timing
- Reset values:
  - All m_img_* outputs = 0.
  - m_lut_valid = 0, m_err_info = 0.
  - FSM in IDLE; histogram RAM treated as cleared (a reset-time clear walk of 2^W cycles runs before the first ACCUM).
  - If fsync rises during the clear walk, it is treated as an overrun.
- Pixel path latency is exactly 2 cycles (input register, LUT read) for data and all sync signals.
- Histogram RMW: read at t, write at t+1. Forwarding covers the t+1 collision.
- CDF duration is 2^W cycles plus 1 SWAP cycle. For W=8 the inter-frame gap must be ≥ 258 cycles.
- **Bank swap:** a pixel entering in the SWAP cycle uses the new LUT; earlier pixels use the old one.
- **Reset mid-CDF:** LUT banks are invalidated (m_lut_valid = 0) and the clear walk restarts.

## Configuration
- HIST_EQ_STATS_EN defined: adds outputs m_stat_min and m_stat_max (each NB_CHN*WD_IMG_DATA).
  - They hold the per-channel min and max sample of the last accumulated frame.
  - They update in the SWAP cycle and reset to 0.
- HIST_EQ_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package hist_eq_pkg holds:
  - the FSM state enum (IDLE, CLEAR, ACCUM, CDF, SWAP);
  - the err bit index constants (ERR_OVR=0, ERR_SAT=1, ERR_CNT=2);
  - functions for WD_BIN and K.
- Sub-module hist_eq_chan: one channel's histogram RAM, forwarding, CDF datapath and LUT banks. It is instantiated NB_CHN times under a generate loop.
- The top level holds the FSM, the pixel counter and the sync delay line.

## Test plan
All scenarios use NB_CHN=1, 16x16 image, W=8 (K=16711680), and ≥300 idle cycles between frames unless stated.
- Frame 1 with pixel = 0..255, one each → after SWAP, m_lut_valid=1. Frame 2 remaps 0→0, 127→127, 255→255 (lut[i] = ((i+1)*K) >> 24).
- Frame of all 100 → next frame: input 99 → 0, input 100 → 255, input 200 → 255.
- 256 consecutive hsync cycles all with value 7, then CDF → lut[6]=0, lut[7]=255, which proves no increment was lost to forwarding.
- Frame of 200 pixels → err = 4'b0100, LUT still swaps.
- fsync rises 10 cycles after the previous fall → err[0]=1. That frame is passed through the prior LUT. The following well-spaced frame accumulates normally.
- Assert i_sys_rst at CDF bin 50 → all outputs 0 within 1 cycle. After release, pixels pass through unchanged until a full frame plus CDF completes.
